run_length_detector: RTL and testbench
======================================

Name: run_length_detector

Overview:
- Parametrised successor to the fixed 3-in-a-row sequence detector FSM.
- Detects RUN_LEN consecutive sampled-high cycles on `change` and emits a one-cycle `detect` pulse.
- Supports a configurable post-detect hold-off and a one-shot or repeat re-arm mode.
- Keeps a saturating detection tally; used as a debounced event qualifier in the sample/control datapath.

Parameters:
- RUN_LEN, 3: consecutive high samples required; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of run_count and detect_total.
- MODE, 0: 0 = one-shot, `change` must be sampled low before re-arm; 1 = repeat, re-arms immediately.
- HOLDOFF, 2: cycles after FIRE during which `change` is ignored; 0 is legal.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  synchronous qualifier; low forces IDLE at the next edge.
- change  in  1  monitored input, sampled on clock rising edge.
- clear_total  in  1  synchronous clear of detect_total.
- run_count  out  CNT_W  current consecutive-high count.
- detect  out  1  registered one-cycle pulse.
- busy  out  1  high in COUNT, FIRE, HOLD, WAIT_LOW.
- detect_total  out  CNT_W  saturating count of detect pulses.

Behaviour:
- Reset (asynchronous, while high):
  - state=IDLE, run_count=0, detect=0, busy=0, detect_total=0, hold counter=0.
  - Asserting reset mid-run drops all outputs without waiting for a clock edge.
- All outputs are registered or are a decode of registered state; no combinational path from inputs to outputs.
- States: IDLE, COUNT, FIRE, HOLD, WAIT_LOW.
- IDLE (run_count=0):
  - enable && change -> COUNT with run_count=1.
  - If RUN_LEN==1 -> FIRE with run_count=1.
- COUNT:
  - change=1 -> run_count+1; if the new value == RUN_LEN -> FIRE, else stay in COUNT.
  - change=0 -> IDLE, run_count=0.
- FIRE:
  - Lasts exactly one cycle; detect=1 only in this state; change is ignored.
  - Next state: HOLDOFF>0 -> HOLD with hold counter loaded to HOLDOFF.
  - Next state: HOLDOFF==0 -> post-detect target.
- HOLD:
  - change is ignored; counter decrements each cycle.
  - When counter==1 at the edge -> post-detect target. HOLD therefore lasts exactly HOLDOFF cycles.
- Post-detect target:
  - MODE=0 -> WAIT_LOW.
  - MODE=1 -> IDLE with run_count=0.
- WAIT_LOW: stays until change is sampled 0, then -> IDLE.
- run_count holds RUN_LEN through FIRE, HOLD and WAIT_LOW, and clears on entry to IDLE.
- Latency: detect is high in the cycle after the edge that samples the RUN_LEN-th consecutive high.
- MODE=1 with change held high: detect period = RUN_LEN+1+HOLDOFF cycles. The first edge back in IDLE samples change and restarts the count at 1.
- enable=0:
  - From any state, goes to IDLE with run_count=0 at the next edge.
  - A FIRE already entered still gives its full single-cycle pulse.
  - detect_total is unaffected.
- detect_total:
  - Increments by 1 on each FIRE entry; saturates at 2^CNT_W-1.
  - clear_total has priority: clear and increment in the same cycle -> 0.
- Illegal parameters: RUN_LEN outside the legal range or MODE outside {0,1} are rejected at elaboration with $error.

Test Plan:
- Defaults; reset released; change=1 for 12 cycles from edge E1 -> run_count=1,2,3 after E1..E3; detect high only in the cycle after E3; busy until change goes low; detect_total=1.
- MODE=1, HOLDOFF=0, change held high for 16 cycles -> detect pulses after E3, E7, E11, E15 (period 4); detect_total=4.
- Defaults; change pattern 1,1,0,1,1,1 -> run_count 1,2,0,1,2,3; a single detect after the 6th edge.
- Reset asserted mid-cycle while run_count=2 -> run_count=0, busy=0 immediately; after release, 3 new highs are needed to detect.
- enable dropped when run_count=2 -> IDLE next edge, no detect; enable dropped during FIRE -> pulse is still exactly 1 cycle.
- CNT_W=2, RUN_LEN=1, MODE=1, HOLDOFF=0, 5 detections -> detect_total saturates at 3; clear_total asserted together with a detect -> detect_total=0.

Source files
------------

// File: rtl/run_length_detector_if.sv
// Control/status bundle for run_length_detector: qualifiers in, count/pulse/tally out.
// No latency of its own; pure wiring between driver and detector.
// No backpressure; all signals are level/pulse sampled on the detector clock.
interface run_length_detector_if #(
  parameter int CNT_W = 4
);
  logic             enable;
  logic             change;
  logic             clear_total;
  logic [CNT_W-1:0] run_count;
  logic             detect;
  logic             busy;
  logic [CNT_W-1:0] detect_total;

  // Driver side: owns the qualifiers, observes the status.
  modport master (
    output enable, change, clear_total,
    input  run_count, detect, busy, detect_total
  );

  // Detector side.
  modport slave (
    input  enable, change, clear_total,
    output run_count, detect, busy, detect_total
  );
endinterface

// File: rtl/run_length_detector.sv
// Flags RUN_LEN consecutive high samples of change with a one-cycle detect pulse.
// detect rises the cycle after the edge sampling the RUN_LEN-th high; all outputs registered.
// No backpressure; post-detect hold-off and one-shot/repeat re-arm gate further detections.
module run_length_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 4,
  parameter int MODE    = 0,
  parameter int HOLDOFF = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  run_length_detector_if.slave   bus
);

  // Reject configurations the counter or re-arm logic cannot represent.
  if (RUN_LEN < 1 || RUN_LEN > (2 ** CNT_W) - 1) begin : g_bad_run_len
    $error("run_length_detector: RUN_LEN %0d outside 1..%0d", RUN_LEN, (2 ** CNT_W) - 1);
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("run_length_detector: MODE %0d must be 0 or 1", MODE);
  end

  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] TOT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNT    = 3'd1,
    FIRE     = 3'd2,
    HOLD     = 3'd3,
    WAIT_LOW = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  run_count_q, run_count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              detect_q, detect_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  total_q, total_d;

  // Next-state, counters and registered-output values for the coming edge.
  always_comb begin
    state_d     = state_q;
    run_count_d = run_count_q;
    hold_d      = hold_q;

    if (!bus.enable) begin
      // A pulse already in FIRE is carried by detect_q for its full cycle.
      state_d     = IDLE;
      run_count_d = '0;
      hold_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.change) begin
            run_count_d = CNT_W'(1);
            state_d     = (RUN_LEN == 1) ? FIRE : COUNT;
          end
        end
        COUNT: begin
          if (bus.change) begin
            run_count_d = run_count_q + CNT_W'(1);
            if (run_count_q + CNT_W'(1) == RUN_LEN_C) begin
              state_d = FIRE;
            end
          end else begin
            state_d     = IDLE;
            run_count_d = '0;
          end
        end
        FIRE: begin
          if (HOLDOFF > 0) begin
            state_d = HOLD;
            hold_d  = HOLD_W'(HOLDOFF);
          end else if (MODE == 0) begin
            state_d = WAIT_LOW;
          end else begin
            state_d     = IDLE;
            run_count_d = '0;
          end
        end
        HOLD: begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) begin
            if (MODE == 0) begin
              state_d = WAIT_LOW;
            end else begin
              state_d     = IDLE;
              run_count_d = '0;
            end
          end
        end
        WAIT_LOW: begin
          if (!bus.change) begin
            state_d     = IDLE;
            run_count_d = '0;
          end
        end
        default: begin
          state_d     = IDLE;
          run_count_d = '0;
          hold_d      = '0;
        end
      endcase
    end

    detect_d = (state_d == FIRE);
    busy_d   = (state_d != IDLE);

    // Clear wins over a same-cycle detection; otherwise saturate on each FIRE entry.
    total_d = total_q;
    if (bus.clear_total) begin
      total_d = '0;
    end else if (state_d == FIRE && total_q != TOT_MAX) begin
      total_d = total_q + CNT_W'(1);
    end
  end

  // State and registered outputs; reset drops everything without waiting for an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      run_count_q <= '0;
      hold_q      <= '0;
      detect_q    <= 1'b0;
      busy_q      <= 1'b0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      run_count_q <= run_count_d;
      hold_q      <= hold_d;
      detect_q    <= detect_d;
      busy_q      <= busy_d;
      total_q     <= total_d;
    end
  end

  assign bus.run_count    = run_count_q;
  assign bus.detect       = detect_q;
  assign bus.busy         = busy_q;
  assign bus.detect_total = total_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector across three parameter sets.
// Outputs are sampled 1 time unit after each rising edge.
// Inputs change only between edges; no backpressure involved.
module tb_run_length_detector;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // A: defaults (RUN_LEN 3, one-shot, hold-off 2)
  run_length_detector_if #(.CNT_W(4)) if_a ();
  run_length_detector #(.RUN_LEN(3), .CNT_W(4), .MODE(0), .HOLDOFF(2))
    dut_a (.clock(clock), .reset(reset), .bus(if_a));

  // B: repeat mode, no hold-off
  run_length_detector_if #(.CNT_W(4)) if_b ();
  run_length_detector #(.RUN_LEN(3), .CNT_W(4), .MODE(1), .HOLDOFF(0))
    dut_b (.clock(clock), .reset(reset), .bus(if_b));

  // C: narrow tally, single-sample run, repeat mode
  run_length_detector_if #(.CNT_W(2)) if_c ();
  run_length_detector #(.RUN_LEN(1), .CNT_W(2), .MODE(1), .HOLDOFF(0))
    dut_c (.clock(clock), .reset(reset), .bus(if_c));

  typedef struct {
    logic en;
    logic ch;
    logic clr;
    int   rc;
    logic det;
    logic busy;
    int   tot;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic en, input logic ch, input logic clr,
                     input int rc, input logic det, input logic busy, input int tot);
    vec_t v;
    v.en = en; v.ch = ch; v.clr = clr;
    v.rc = rc; v.det = det; v.busy = busy; v.tot = tot;
    vecs.push_back(v);
  endtask

  initial begin
    // Vector table for DUT A: inputs before an edge, expected outputs after it.
    // 12 highs then low: count 1,2,3, pulse after 3rd edge, busy through hold-off and wait-low.
    add(1,1,0, 1,0,1,0);
    add(1,1,0, 2,0,1,0);
    add(1,1,0, 3,1,1,1);
    for (int i = 0; i < 9; i++) add(1,1,0, 3,0,1,1);
    add(1,0,0, 0,0,0,1);
    // Broken run: 1,1,0,1,1,1
    add(1,1,0, 1,0,1,1);
    add(1,1,0, 2,0,1,1);
    add(1,0,0, 0,0,0,1);
    add(1,1,0, 1,0,1,1);
    add(1,1,0, 2,0,1,1);
    add(1,1,0, 3,1,1,2);
    add(1,0,0, 3,0,1,2);  // HOLD
    add(1,0,0, 3,0,1,2);  // HOLD last cycle
    add(1,0,0, 3,0,1,2);  // WAIT_LOW
    add(1,0,0, 0,0,0,2);  // low sampled -> IDLE
    // enable dropped at run_count 2
    add(1,1,0, 1,0,1,2);
    add(1,1,0, 2,0,1,2);
    add(0,1,0, 0,0,0,2);
    add(0,1,0, 0,0,0,2);
    // enable dropped during FIRE: pulse still exactly one cycle
    add(1,1,0, 1,0,1,2);
    add(1,1,0, 2,0,1,2);
    add(1,1,0, 3,1,1,3);
    add(0,1,0, 0,0,0,3);
    add(0,0,1, 0,0,0,0);
    add(1,0,0, 0,0,0,0);

    {if_a.enable, if_a.change, if_a.clear_total} = 3'b000;
    {if_b.enable, if_b.change, if_b.clear_total} = 3'b000;
    {if_c.enable, if_c.change, if_c.clear_total} = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    chk("a_reset_rc",   int'(if_a.run_count),    0);
    chk("a_reset_det",  int'(if_a.detect),       0);
    chk("a_reset_busy", int'(if_a.busy),         0);
    chk("a_reset_tot",  int'(if_a.detect_total), 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      if_a.enable      = vecs[i].en;
      if_a.change      = vecs[i].ch;
      if_a.clear_total = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_rc", i),   int'(if_a.run_count),    vecs[i].rc);
      chk($sformatf("vec%0d_det", i),  int'(if_a.detect),       int'(vecs[i].det));
      chk($sformatf("vec%0d_busy", i), int'(if_a.busy),         int'(vecs[i].busy));
      chk($sformatf("vec%0d_tot", i),  int'(if_a.detect_total), vecs[i].tot);
    end

    // Asynchronous reset mid-run at run_count 2, then a fresh run of 3 is needed.
    if_a.enable = 1'b1;
    if_a.change = 1'b1;
    step();
    step();
    chk("a_pre_reset_rc", int'(if_a.run_count), 2);
    #3 reset = 1'b1;
    #1;
    chk("a_async_rc",   int'(if_a.run_count), 0);
    chk("a_async_busy", int'(if_a.busy),      0);
    #1 reset = 1'b0;
    step();
    chk("a_post_rst_rc1", int'(if_a.run_count), 1);
    chk("a_post_rst_det1", int'(if_a.detect),   0);
    step();
    chk("a_post_rst_det2", int'(if_a.detect),   0);
    step();
    chk("a_post_rst_det3", int'(if_a.detect),   1);
    chk("a_post_rst_tot",  int'(if_a.detect_total), 1);
    if_a.enable = 1'b0;
    if_a.change = 1'b0;

    // DUT B: change held high 16 edges, pulses after edges 3,7,11,15.
    if_b.enable = 1'b1;
    if_b.change = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      chk($sformatf("b_det_e%0d", e), int'(if_b.detect),    (e % 4 == 3) ? 1 : 0);
      chk($sformatf("b_rc_e%0d", e),  int'(if_b.run_count), e % 4);
    end
    chk("b_total", int'(if_b.detect_total), 4);
    if_b.change = 1'b0;

    // DUT C: a detection every other edge; tally saturates at 3.
    if_c.enable = 1'b1;
    if_c.change = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk($sformatf("c_det_e%0d", e), int'(if_c.detect), e % 2);
      chk($sformatf("c_tot_e%0d", e), int'(if_c.detect_total), ((e + 1) / 2 > 3) ? 3 : (e + 1) / 2);
    end
    // Clear coincident with a FIRE entry wins.
    if_c.clear_total = 1'b1;
    step();
    chk("c_clr_det", int'(if_c.detect),       1);
    chk("c_clr_tot", int'(if_c.detect_total), 0);
    if_c.clear_total = 1'b0;
    step();
    chk("c_after_clr_tot0", int'(if_c.detect_total), 0);
    step();
    chk("c_after_clr_tot1", int'(if_c.detect_total), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
